input_buffer_queue: RTL and testbench
=====================================

Name: input_buffer_queue

Overview:
- Parametrised circular FIFO of N-lane vectors. It is the next-generation input buffer at the front of the trace pipeline, ahead of the filter/reduce stages.
- Adds the following over the current buffer:
  - real dequeue handshake;
  - full/empty/almost-full status;
  - occupancy count;
  - per-entry stored EOF tag (EOF stays aligned with its vector);
  - sticky overflow flag.
- Storage is a single simple-dual-port RAM, N*DATA_WIDTH+1 bits wide and IB_DEPTH deep, with registered read output.

Parameters:
- N, 8, number of vector lanes.
- DATA_WIDTH, 32, bits per lane.
- IB_DEPTH, 4, queue entries; must be a power of 2 and >= 2.
- ALMOST_FULL_LEVEL, IB_DEPTH-1, occupancy at or above which almost_full asserts; range 1..IB_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enqueue  in  1  write request for vector_in/eof_in this cycle.
- eof_in  in  1  end-of-frame tag for the enqueued vector.
- vector_in  in  DATA_WIDTH x N (unpacked [N-1:0])  input vector.
- dequeue  in  1  read request.
- valid_out  out  1  vector_out/eof_out hold a dequeued entry this cycle.
- eof_out  out  1  EOF tag stored with the output entry.
- vector_out  out  DATA_WIDTH x N (unpacked [N-1:0])  output vector.
- full  out  1  occupancy == IB_DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= ALMOST_FULL_LEVEL.
- occupancy  out  $clog2(IB_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky: an enqueue was dropped.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr=0, rd_ptr=0, occupancy=0;
  - valid_out=0, eof_out=0, vector_out all lanes 0;
  - overflow=0, full=0, empty=1, almost_full=0.
  - RAM contents are not cleared and must not be observable.
  - Reset mid-operation discards all entries; any read in flight produces no valid_out.
- Accept rules, evaluated on the current-cycle registered state:
  - deq_acc = dequeue && !empty.
  - enq_acc = enqueue && (!full || deq_acc).
- Write path:
  - On enq_acc, write {eof_in, vector_in} at wr_ptr (lane 0 in the LSBs).
  - Then wr_ptr <= wr_ptr+1, wrapping modulo IB_DEPTH.
- Read path:
  - On deq_acc, read address rd_ptr, then rd_ptr <= rd_ptr+1 (wrap).
  - Data appears on vector_out/eof_out with valid_out=1 exactly 1 cycle after the accepting edge (latency 1).
- Output hold:
  - When no dequeue was accepted, valid_out=0 on the next cycle.
  - vector_out/eof_out hold their last values; the bench checks them only when valid_out=1.
- Occupancy:
  - +1 on enq_acc only; -1 on deq_acc only; unchanged on both or neither.
  - full, empty and almost_full are registered and derived from the next occupancy, so they are valid in the same cycle as occupancy.
- Empty with simultaneous enqueue+dequeue:
  - The dequeue is rejected (no bypass) and the enqueue is accepted.
  - The entry is readable from the next cycle.
- Full with simultaneous enqueue+dequeue: both are accepted and occupancy stays IB_DEPTH.
- Full with enqueue only:
  - The vector is dropped and overflow <= 1.
  - overflow is cleared only by reset.
- Dequeue on empty: ignored, no pointer change, valid_out=0 on the next cycle.
- Ordering: strict FIFO across pointer wrap-around.
- RAM read-during-write (same address) cannot occur for accepted operations except when full with both accepted. In that case read and write target the same slot, and the read must return the OLD data. Implement as read-first, or bypass-protect explicitly.

Test Plan:
Bench configuration for all scenarios: N=4, DATA_WIDTH=8, IB_DEPTH=4, ALMOST_FULL_LEVEL=3.

1. Basic order: enqueue vectors {k,k+1,k+2,k+3} for k=0x10,0x20,0x30 on 3 cycles, then dequeue 3 cycles -> valid_out on 3 consecutive cycles, one cycle after each dequeue, outputs in order; occupancy goes 1,2,3,2,1,0; almost_full=1 only at occupancy 3.
2. Overflow: 5 enqueues with dequeue=0 -> full=1 after the 4th; 5th dropped, overflow=1 and stays 1; dequeuing 4 returns only the first 4 vectors; then empty=1.
3. Empty corner: occupancy 0, enqueue+dequeue in the same cycle with value 0xAA in all lanes -> no valid_out next cycle, occupancy=1; dequeue next cycle -> 0xAA with valid_out one cycle later.
4. Full corner and wrap: fill with A,B,C,D, then 6 cycles of enqueue+dequeue with E..J -> occupancy stays 4, outputs A..F in order, no overflow, pointers wrap correctly.
5. EOF alignment: enqueue 3 vectors with eof_in=0,1,0, stall 2 cycles, dequeue -> eof_out=0,1,0 coincident with the matching vectors.
6. Reset mid-operation: occupancy 3 with a dequeue accepted, assert reset_n=0 asynchronously between edges -> valid_out, overflow and occupancy go 0 and empty goes 1 immediately; after release a dequeue yields no valid_out.

Source files
------------

// File: rtl/input_buffer_queue.sv
// input_buffer_queue: circular FIFO of N-lane vectors with a stored EOF tag.
// Storage is one simple-dual-port RAM ({eof, lanes}, lane 0 in the LSBs)
// with a registered read port. Status flags and occupancy are registered.
// Overflow is sticky until reset.
module input_buffer_queue #(
    parameter int unsigned N                 = 8,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned IB_DEPTH          = 4,
    parameter int unsigned ALMOST_FULL_LEVEL = IB_DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enqueue,
    input  logic                        eof_in,
    input  logic [DATA_WIDTH-1:0]       vector_in [N-1:0],
    input  logic                        dequeue,
    output logic                        valid_out,
    output logic                        eof_out,
    output logic [DATA_WIDTH-1:0]       vector_out [N-1:0],
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [$clog2(IB_DEPTH):0]   occupancy,
    output logic                        overflow
);

    localparam int unsigned AW = $clog2(IB_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = N * DATA_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(IB_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WW-1:0] mem [IB_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] rd_word_q, rd_word_d;

    logic          deq_acc;
    logic          enq_acc;
    logic [WW-1:0] wr_word;

    // Accept decisions and next-state computation from the registered state.
    // The RAM is read combinationally here and captured at the edge, so a
    // same-slot write on that edge (full with both accepted) returns old data.
    always_comb begin
        deq_acc = dequeue && !empty_q;
        enq_acc = enqueue && (!full_q || deq_acc);

        wr_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            wr_word[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
        end
        wr_word[WW-1] = eof_in;

        wr_ptr_d  = enq_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = deq_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_word_d = deq_acc ? mem[rd_ptr_q] : rd_word_q;
        valid_d   = deq_acc;

        occ_d = occ_q;
        case ({enq_acc, deq_acc})
            2'b10:   occ_d = occ_q + ONE_C;
            2'b01:   occ_d = occ_q - ONE_C;
            default: occ_d = occ_q;
        endcase

        full_d  = (occ_d == DEPTH_C);
        empty_d = (occ_d == '0);
        afull_d = (occ_d >= AF_C);
        ovf_d   = ovf_q || (enqueue && !enq_acc);
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            rd_word_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            rd_word_q <= rd_word_d;
        end
    end

    // RAM write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (enq_acc) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    // Unpack the registered read word onto the lane outputs.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            vector_out[i] = rd_word_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        eof_out = rd_word_q[WW-1];
    end

    assign valid_out   = valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign occupancy   = occ_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_input_buffer_queue.sv
// Directed bench for input_buffer_queue (N=4, DATA_WIDTH=8, depth 4, AF=3).
// A queue of expected {eof, vector} words is pushed on accepted enqueues and
// popped when a dequeue is accepted; outputs are compared one cycle later.
module tb_input_buffer_queue;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enqueue = 1'b0;
    logic          eof_in = 1'b0;
    logic          dequeue = 1'b0;
    logic [DW-1:0] vector_in  [N-1:0];
    logic [DW-1:0] vector_out [N-1:0];
    logic          valid_out, eof_out, full, empty, almost_full, overflow;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    input_buffer_queue #(
        .N                 (N),
        .DATA_WIDTH        (DW),
        .IB_DEPTH          (D),
        .ALMOST_FULL_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enqueue     (enqueue),
        .eof_in      (eof_in),
        .vector_in   (vector_in),
        .dequeue     (dequeue),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .vector_out  (vector_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .occupancy   (occupancy),
        .overflow    (overflow)
    );

    int unsigned   n_total = 0;
    int unsigned   n_pass  = 0;
    logic [32:0]   sb [$];
    int            mocc = 0;
    bit            movf = 1'b0;
    bit            exp_valid = 1'b0;
    logic [32:0]   exp_word = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vout_packed();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = vector_out[i];
        return r;
    endfunction

    task automatic drive_vec(input logic [31:0] v);
        for (int i = 0; i < N; i++) vector_in[i] = v[i*DW +: DW];
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
        if (exp_valid) begin
            check({tag, ".vec"}, 64'(vout_packed()), 64'(exp_word[31:0]));
            check({tag, ".eof"}, 64'(eof_out), 64'(exp_word[32]));
        end
        check({tag, ".occ"},   64'(occupancy),   64'(mocc));
        check({tag, ".full"},  64'(full),        64'(mocc == D));
        check({tag, ".empty"}, 64'(empty),       64'(mocc == 0));
        check({tag, ".afull"}, 64'(almost_full), 64'(mocc >= AF));
        check({tag, ".ovf"},   64'(overflow),    64'(movf));
    endtask

    // One clock cycle: drive, update the reference, then sample after the edge.
    task automatic cycle(input bit enq, input bit eof, input logic [31:0] v,
                         input bit deq, input string tag);
        bit da, ea;
        enqueue = enq;
        eof_in  = eof;
        drive_vec(v);
        dequeue = deq;
        da = deq && (mocc != 0);
        ea = enq && ((mocc != D) || da);
        exp_valid = da;
        if (da) exp_word = sb.pop_front();
        if (ea) sb.push_back({eof, v});
        if (enq && !ea) movf = 1'b1;
        mocc = mocc + int'(ea) - int'(da);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    function automatic logic [31:0] bytes4(input logic [7:0] k);
        return {k + 8'd3, k + 8'd2, k + 8'd1, k};
    endfunction

    initial begin
        drive_vec('0);

        // Reset state, sampled mid-cycle while reset is held.
        #12;
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.vec",   64'(vout_packed()), 64'd0);
        check("rst.eof",   64'(eof_out), 64'd0);
        check("rst.occ",   64'(occupancy), 64'd0);
        check("rst.full",  64'(full), 64'd0);
        check("rst.empty", 64'(empty), 64'd1);
        check("rst.afull", 64'(almost_full), 64'd0);
        check("rst.ovf",   64'(overflow), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ordering with occupancy 1,2,3,2,1,0.
        cycle(1, 0, bytes4(8'h10), 0, "s1_enq0");
        cycle(1, 0, bytes4(8'h20), 0, "s1_enq1");
        cycle(1, 0, bytes4(8'h30), 0, "s1_enq2");
        cycle(0, 0, '0, 1, "s1_deq0");
        cycle(0, 0, '0, 1, "s1_deq1");
        cycle(0, 0, '0, 1, "s1_deq2");
        cycle(0, 0, '0, 0, "s1_idle");

        // Empty corner: simultaneous enqueue+dequeue, dequeue rejected.
        cycle(1, 0, 32'hAAAA_AAAA, 1, "s3_both");
        cycle(0, 0, '0, 1, "s3_deq");
        cycle(0, 0, '0, 0, "s3_idle");

        // Full corner with wrap-around.
        for (int i = 0; i < 4; i++) cycle(1, 0, bytes4(8'hA0 + 8'(i * 4)), 0, "s4_fill");
        for (int i = 0; i < 6; i++) cycle(1, 0, bytes4(8'hC0 + 8'(i * 4)), 1, "s4_both");
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, "s4_drain");
        cycle(0, 0, '0, 1, "s4_deq_empty");

        // EOF alignment.
        cycle(1, 0, bytes4(8'h50), 0, "s5_enq0");
        cycle(1, 1, bytes4(8'h54), 0, "s5_enq1");
        cycle(1, 0, bytes4(8'h58), 0, "s5_enq2");
        cycle(0, 0, '0, 0, "s5_stall0");
        cycle(0, 0, '0, 0, "s5_stall1");
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, "s5_deq");

        // Overflow: fifth enqueue dropped, flag sticks.
        for (int i = 0; i < 5; i++) cycle(1, 0, bytes4(8'h60 + 8'(i * 4)), 0, "s2_enq");
        cycle(0, 0, '0, 0, "s2_idle");
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, "s2_deq");
        cycle(0, 0, '0, 1, "s2_deq_empty");

        // Reset mid-operation with a read just accepted.
        cycle(1, 0, bytes4(8'h70), 0, "s6_enq0");
        cycle(1, 1, bytes4(8'h74), 0, "s6_enq1");
        cycle(1, 0, bytes4(8'h78), 0, "s6_enq2");
        cycle(0, 0, '0, 1, "s6_deq");
        enqueue = 1'b0;
        dequeue = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_rst.valid", 64'(valid_out), 64'd0);
        check("s6_rst.ovf",   64'(overflow), 64'd0);
        check("s6_rst.occ",   64'(occupancy), 64'd0);
        check("s6_rst.empty", 64'(empty), 64'd1);
        check("s6_rst.full",  64'(full), 64'd0);
        sb.delete();
        mocc = 0;
        movf = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, '0, 1, "s6_post_deq");
        cycle(0, 0, '0, 0, "s6_post_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
